entropy_collector: RTL and testbench

- Downstream consumer of the online-health-test stream. Accepts the raw entropy bit each cycle once the health test reports `valid`, and packs bits into fixed-width words.
- Buffers words in a small FIFO and presents them to the conditioner over a valid/ready handshake.
- Drives the `full` back-pressure signal that freezes the health test's sample pipeline, and locks out permanently on `perm_fail`.

---
 rtl/entropy_collector_pkg.sv | 7 +
 rtl/entropy_fifo.sv | 49 ++++
 rtl/entropy_collector.sv | 87 ++++++++
 tb/tb_entropy_collector.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/entropy_collector_pkg.sv
// entropy_collector_pkg: shared defaults and state type for the entropy collector
package entropy_collector_pkg;
    localparam int ENTROPY_WORD_W     = 64;
    localparam int ENTROPY_FIFO_DEPTH = 4;
    localparam int COLLECT_CNT_W      = 16;
    typedef enum logic [1:0] {WAIT_VALID, COLLECT, FAULT} collector_state_t;
endpackage

// File: rtl/entropy_fifo.sv
// entropy_fifo: synchronous word FIFO with push/pop/flush for the entropy collector
//   clk, rst     clock and active-low synchronous reset
//   push_i       write data_i (ignored when full)
//   pop_i        drop head word (ignored when empty)
//   flush_i      empty the FIFO next cycle, overriding push/pop
//   data_o       head word, zero when empty
//   count_o      words held
//   empty_o      no words held
module entropy_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && cnt_q != CW'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    // Pointers are power-of-two wide, so they wrap without explicit compare.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PW'(do_push);
            rd_q  <= rd_q + PW'(do_pop);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/entropy_collector.sv
// entropy_collector: packs health-tested entropy bits into words and buffers them for the conditioner
//   clk, rst       clock and active-low synchronous reset
//   bit_in         raw entropy bit
//   oht_valid      health test reached good-entropy status
//   oht_perm_fail  health test permanent failure
//   full           back-pressure; no bit accepted this cycle
//   out_data       FIFO head word (zero when empty)
//   out_valid      head word available
//   out_ready      downstream accepts out_data
//   fault          sticky permanent-failure flag
//   words_out      saturating count of words popped
module entropy_collector
    import entropy_collector_pkg::*;
#(
    parameter int WORD_W     = ENTROPY_WORD_W,
    parameter int FIFO_DEPTH = ENTROPY_FIFO_DEPTH,
    parameter int CNT_W      = COLLECT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              oht_valid,
    input  logic              oht_perm_fail,
    output logic              full,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              fault,
    output logic [CNT_W-1:0]  words_out
);
    localparam int BW  = $clog2(WORD_W);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    collector_state_t  state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d, word;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [FCW-1:0]    fifo_cnt;
    logic              fifo_empty, accept, word_done, pop, fault_entry;
    // A permanent failure pre-empts acceptance and popping in the same cycle.
    assign fault_entry = oht_perm_fail && state_q != FAULT;
    assign accept      = state_q == COLLECT && !full && !oht_perm_fail;
    assign word_done   = accept && bcnt_q == BW'(WORD_W - 1);
    assign pop         = out_valid && out_ready && !oht_perm_fail;
    assign word        = {shift_q[WORD_W-2:0], bit_in};
    assign words_out   = words_q;
    always_ff @(posedge clk) begin
        if (!rst) state_q <= WAIT_VALID;
        else      state_q <= state_d;
    end
    always_comb begin
        state_d = oht_perm_fail ? FAULT :
                  (state_q == WAIT_VALID && oht_valid) ? COLLECT : state_q;
    end
    // full and out_valid depend only on registered state.
    always_comb begin
        full      = fifo_cnt == FCW'(FIFO_DEPTH) || state_q == FAULT;
        out_valid = !fifo_empty && state_q != FAULT;
        fault     = state_q == FAULT;
    end
    always_comb begin
        shift_d = fault_entry ? '0 : accept ? word : shift_q;
        bcnt_d  = fault_entry ? '0 : word_done ? '0 : accept ? bcnt_q + 1'b1 : bcnt_q;
        words_d = (pop && words_q != '1) ? words_q + 1'b1 : words_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            bcnt_q  <= '0;
            words_q <= '0;
        end else begin
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            words_q <= words_d;
        end
    end
    entropy_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (word_done),
        .pop_i   (pop),
        .flush_i (fault_entry),
        .data_i  (word),
        .data_o  (out_data),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_entropy_collector.sv
// tb_entropy_collector: directed self-checking bench for entropy_collector (8-bit words, 2-deep FIFO, 4-bit counter)
module tb_entropy_collector;
    logic       clk = 1'b0;
    logic       rst, bit_in, oht_valid, oht_perm_fail, out_ready;
    logic       full, out_valid, fault;
    logic [7:0] out_data;
    logic [3:0] words_out;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       saw_full;

    entropy_collector #(.WORD_W(8), .FIFO_DEPTH(2), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_in        (bit_in),
        .oht_valid     (oht_valid),
        .oht_perm_fail (oht_perm_fail),
        .full          (full),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fault         (fault),
        .words_out     (words_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
        if (full) saw_full = 1'b1;
    endtask

    task automatic do_reset;
        rst = 1'b0; oht_valid = 1'b0; oht_perm_fail = 1'b0; out_ready = 1'b0; bit_in = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic start_collect;
        oht_valid = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r_body, input logic r_last);
        for (int i = 7; i >= 0; i--) begin
            bit_in = b[i];
            out_ready = (i == 0) ? r_last : r_body;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; oht_valid = 1'b0; oht_perm_fail = 1'b0; out_ready = 1'b0; bit_in = 1'b0;
        repeat (3) tick();
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b exp 0", full); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h exp 00", out_data); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b exp 0", fault); end
        n_cmp++; if (words_out !== 4'h0) begin n_bad++; $display("FAIL reset_words: got %h exp 0", words_out); end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bit_in = i[0];
            tick();
        end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL idle_full: got %b exp 0", full); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b exp 0", out_valid); end
        n_cmp++; if (words_out !== 4'h0) begin n_bad++; $display("FAIL idle_words: got %h exp 0", words_out); end
    endtask

    // Continues from the idle state left by test_reset: bits seen while waiting must not count.
    task automatic test_packing;
        logic [7:0] b;
        b = 8'hB2;
        start_collect();
        for (int i = 7; i >= 0; i--) begin
            bit_in = b[i];
            tick();
            if (i == 1) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pack_early_valid: got %b exp 0", out_valid); end
            end
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pack_valid: got %b exp 1", out_valid); end
        n_cmp++; if (out_data !== 8'hB2) begin n_bad++; $display("FAIL pack_data: got %h exp b2", out_data); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL pack_full: got %b exp 0", full); end
    endtask

    task automatic test_back_pressure;
        do_reset();
        start_collect();
        send_byte(8'hFF, 1'b0, 1'b0);
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL bp_one_full: got %b exp 0", full); end
        send_byte(8'h0F, 1'b0, 1'b0);
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL bp_full: got %b exp 1", full); end
        for (int i = 0; i < 5; i++) begin
            bit_in = 1'b1;
            tick();
        end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL bp_hold_full: got %b exp 1", full); end
        n_cmp++; if (out_data !== 8'hFF) begin n_bad++; $display("FAIL bp_head: got %h exp ff", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b exp 0", full); end
        n_cmp++; if (out_data !== 8'h0F) begin n_bad++; $display("FAIL bp_next: got %h exp 0f", out_data); end
        n_cmp++; if (words_out !== 4'h1) begin n_bad++; $display("FAIL bp_words: got %h exp 1", words_out); end
        // A clean A5 proves the five blocked bits never entered the shift register.
        send_byte(8'hA5, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_data !== 8'hA5) begin n_bad++; $display("FAIL bp_after: got %h exp a5", out_data); end
        n_cmp++; if (words_out !== 4'h2) begin n_bad++; $display("FAIL bp_words2: got %h exp 2", words_out); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        start_collect();
        send_byte(8'h3C, 1'b0, 1'b0);
        saw_full = 1'b0;
        send_byte(8'h5A, 1'b0, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pp_valid: got %b exp 1", out_valid); end
        n_cmp++; if (out_data !== 8'h5A) begin n_bad++; $display("FAIL pp_data: got %h exp 5a", out_data); end
        n_cmp++; if (words_out !== 4'h1) begin n_bad++; $display("FAIL pp_words: got %h exp 1", words_out); end
        n_cmp++; if (saw_full !== 1'b0) begin n_bad++; $display("FAIL pp_never_full: got %b exp 0", saw_full); end
    endtask

    task automatic test_fault;
        do_reset();
        start_collect();
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            tick();
        end
        out_ready = 1'b1;
        oht_perm_fail = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flt_valid: got %b exp 0", out_valid); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL flt_full: got %b exp 1", full); end
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL flt_fault: got %b exp 1", fault); end
        n_cmp++; if (words_out !== 4'h0) begin n_bad++; $display("FAIL flt_words: got %h exp 0", words_out); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL flt_flush: got %h exp 00", out_data); end
        oht_perm_fail = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_in = i[0];
            tick();
        end
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL flt_sticky: got %b exp 1", fault); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL flt_sticky_full: got %b exp 1", full); end
        n_cmp++; if (words_out !== 4'h0) begin n_bad++; $display("FAIL flt_sticky_words: got %h exp 0", words_out); end
        do_reset();
        tick();
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL flt_clear: got %b exp 0", fault); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL flt_clear_full: got %b exp 0", full); end
        oht_valid = 1'b1;
        oht_perm_fail = 1'b1;
        tick();
        oht_perm_fail = 1'b0;
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL flt_from_wait: got %b exp 1", fault); end
        do_reset();
        start_collect();
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            tick();
        end
        do_reset();
        start_collect();
        send_byte(8'hC3, 1'b0, 1'b0);
        n_cmp++; if (out_data !== 8'hC3) begin n_bad++; $display("FAIL rst_midword: got %h exp c3", out_data); end
    endtask

    task automatic test_saturation;
        do_reset();
        start_collect();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i * 7 + 1), 1'b1, 1'b1);
            if (i == 3) begin
                n_cmp++; if (words_out !== 4'h3) begin n_bad++; $display("FAIL sat_mid: got %h exp 3", words_out); end
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (words_out !== 4'hF) begin n_bad++; $display("FAIL sat_words: got %h exp f", words_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sat_drained: got %b exp 0", out_valid); end
    endtask

    initial begin
        saw_full = 1'b0;
        test_reset();
        test_packing();
        test_back_pressure();
        test_back_to_back();
        test_fault();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
